// File: rtl/and2_pkg.sv
// Shared defaults for the and2 block: operand width, counter width and the
// all-ones value the activity counter saturates at.
package and2_pkg;

    localparam int WIDTH_DEF = 1;
    localparam int CNT_W_DEF = 16;

    localparam logic [CNT_W_DEF-1:0] CNT_MAX_DEF = {CNT_W_DEF{1'b1}};

endpackage : and2_pkg

// File: rtl/and2_sat_cnt.sv
// Saturating up-counter: clears on rst or clr, otherwise counts inc pulses
// and sticks at all-ones instead of wrapping.
module and2_sat_cnt
    import and2_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Count register; rst outranks clr, which outranks the increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule : and2_sat_cnt

// File: rtl/and2.sv
// Bitwise AND with a registered copy, per-bit rising-edge flags and a
// saturating count of cycles in which the AND result was nonzero.
module and2
    import and2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_q,
    output logic [WIDTH-1:0] c_rise,
    output logic [CNT_W-1:0] hi_cnt
);

    logic [WIDTH-1:0] c_s;
    logic             c_nz_s;
    logic [WIDTH-1:0] c_q_r;
    logic [WIDTH-1:0] c_rise_r;

    // Purely combinational so c is valid even while the clock is stopped.
    assign c_s    = a & b;
    assign c_nz_s = |c_s;

    // Edge flags compare against the pre-edge c_q, so a held bit pulses once.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q_r    <= '0;
            c_rise_r <= '0;
        end else begin
            c_q_r    <= c_s;
            c_rise_r <= c_s & ~c_q_r;
        end
    end

    and2_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (c_nz_s),
        .cnt (hi_cnt)
    );

    assign c      = c_s;
    assign c_q    = c_q_r;
    assign c_rise = c_rise_r;

endmodule : and2

// File: tb/tb_and2.sv
// Bench for and2: a 1-bit/16-bit instance and a 4-bit/4-bit instance, both
// checked every cycle against a behavioural model plus literal scenarios.
module tb_and2;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic       clr;
    logic       a0, b0;
    logic [3:0] a1, b1;

    logic        c0, cq0, rise0;
    logic [15:0] cnt0;
    logic [3:0]  c1, cq1, rise1;
    logic [3:0]  cnt1;

    int checks   = 0;
    int failures = 0;

    // model state
    bit         m_ok = 1'b0;
    logic       m0_cq, m0_rise;
    int         m0_cnt;
    logic [3:0] m1_cq, m1_rise;
    int         m1_cnt;

    and2 u0 (
        .clk(clk), .rst(rst), .a(a0), .b(b0), .clr_cnt(clr),
        .c(c0), .c_q(cq0), .c_rise(rise0), .hi_cnt(cnt0)
    );

    and2 #(.WIDTH(4), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .clr_cnt(clr),
        .c(c1), .c_q(cq1), .c_rise(rise1), .hi_cnt(cnt1)
    );

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Reference: registered view of the AND, rise = newly-set bits,
    // counter = number of nonzero cycles since clear, capped.
    always @(posedge clk) begin
        if (rst) begin
            m0_cq = 1'b0; m0_rise = 1'b0; m0_cnt = 0;
            m1_cq = 4'd0; m1_rise = 4'd0; m1_cnt = 0;
            m_ok  = 1'b1;
        end else begin
            m0_rise = (a0 & b0) & ~m0_cq;
            m0_cq   = a0 & b0;
            m0_cnt  = clr ? 0 : (((a0 & b0) != 1'b0) ? ((m0_cnt + 1 > 65535) ? 65535 : m0_cnt + 1) : m0_cnt);
            m1_rise = (a1 & b1) & ~m1_cq;
            m1_cq   = a1 & b1;
            m1_cnt  = clr ? 0 : (((a1 & b1) != 4'd0) ? ((m1_cnt + 1 > 15) ? 15 : m1_cnt + 1) : m1_cnt);
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_c0",    32'(c0),    32'(a0 & b0));
            chk("m_cq0",   32'(cq0),   32'(m0_cq));
            chk("m_rise0", 32'(rise0), 32'(m0_rise));
            chk("m_cnt0",  32'(cnt0),  32'(m0_cnt));
            chk("m_c1",    32'(c1),    32'(a1 & b1));
            chk("m_cq1",   32'(cq1),   32'(m1_cq));
            chk("m_rise1", 32'(rise1), 32'(m1_rise));
            chk("m_cnt1",  32'(cnt1),  32'(m1_cnt));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int rises;

    initial begin
        clk_en = 1'b0;
        rst = 1'b1; clr = 1'b0;
        a0 = 1'b0; b0 = 1'b0; a1 = 4'd0; b1 = 4'd0;

        // combinational truth table with the clock idle
        a0 = 1'b0; b0 = 1'b0; #5 chk("and_00", 32'(c0), 32'd0);
        a0 = 1'b1; b0 = 1'b0; #5 chk("and_10", 32'(c0), 32'd0);
        a0 = 1'b1; b0 = 1'b1; #5 chk("and_11", 32'(c0), 32'd1);
        a0 = 1'b0; b0 = 1'b1; #5 chk("and_01", 32'(c0), 32'd0);
        a0 = 1'b0; b0 = 1'bx; #5 chk("and_0x", 32'(c0), 32'd0);
        a0 = 1'b1; b0 = 1'bx; #5 chk("and_1x", 32'(c0), 32'(1'bx));
        a1 = 4'b1100; b1 = 4'b1010; #5 chk("and_w4", 32'(c1), 32'h8);

        // reset held two cycles with c=1
        a0 = 1'b1; b0 = 1'b1;
        clk_en = 1'b1;
        tick(2);
        chk("rst_c",    32'(c0),    32'd1);
        chk("rst_cq",   32'(cq0),   32'd0);
        chk("rst_rise", 32'(rise0), 32'd0);
        chk("rst_cnt",  32'(cnt0),  32'd0);
        rst = 1'b0;
        tick(1);
        chk("rel_cq",    32'(cq0),   32'd1);
        chk("rel_rise",  32'(rise0), 32'd1);
        chk("rel_cnt",   32'(cnt0),  32'd1);
        chk("w4_cq",     32'(cq1),   32'h8);
        chk("w4_rise",   32'(rise1), 32'h8);
        tick(1);
        chk("rel2_rise", 32'(rise0), 32'd0);
        chk("rel2_cnt",  32'(cnt0),  32'd2);

        // five high edges then three low edges
        rst = 1'b1; tick(1); rst = 1'b0;
        rises = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            rises += int'(rise0);
        end
        chk("hold5_cnt", 32'(cnt0), 32'd5);
        b0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            rises += int'(rise0);
            chk("low_cnt", 32'(cnt0), 32'd5);
        end
        chk("one_rise", 32'(rises), 32'd1);

        // clear beats increment; clr leaves c_q alone
        b0 = 1'b1;
        tick(2);
        chk("pre_clr", 32'(cnt0), 32'd7);
        clr = 1'b1;
        tick(1);
        chk("clr_cnt", 32'(cnt0), 32'd0);
        chk("clr_cq",  32'(cq0),  32'd1);
        clr = 1'b0;
        tick(1);
        chk("post_clr", 32'(cnt0), 32'd1);

        // saturation on the 4-bit counter, after a mid-count reset
        rst = 1'b1; tick(1);
        chk("midrst_cnt", 32'(cnt1), 32'd0);
        rst = 1'b0;
        a1 = 4'b0001; b1 = 4'b0001;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            chk("sat_cnt", 32'(cnt1), 32'((i > 15) ? 15 : i));
        end
        tick(2);
        chk("sat_hold", 32'(cnt1), 32'd15);

        // randomized traffic, checked by the model process
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(31) == 0);
            clr = ($urandom_range(7) == 0);
            a0  = 1'($urandom);
            b0  = 1'($urandom);
            a1  = 4'($urandom);
            b1  = ($urandom_range(3) == 0) ? a1 : 4'($urandom);
            tick(1);
        end

        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_and2

// File: doc/and2.md
AND2 -- requirements
Module: and2

Interface
REQ-001 SHALL have parameter WIDTH, default 1, which sets the bit width of a, b, c, c_q and c_rise.
REQ-002 SHALL have parameter CNT_W, default 16, which sets the width of hi_cnt.
REQ-003 SHALL have one clock and reset that is synchronous and active-high; ports named clk and rst.
REQ-004 Port clk, input, 1: rising-edge clock for all registered outputs.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port a, input, WIDTH: operand A.
REQ-007 Port b, input, WIDTH: operand B.
REQ-008 Port clr_cnt, input, 1: synchronous clear of hi_cnt.
REQ-009 Port c, output, WIDTH: combinational bitwise AND of a and b.
REQ-010 Port c_q, output, WIDTH: registered copy of c.
REQ-011 Port c_rise, output, WIDTH: per-bit rising-edge flag of c_q.
REQ-012 Port hi_cnt, output, CNT_W: saturating count of cycles in which c was nonzero.

Function
REQ-013 c SHALL equal a & b bitwise, with zero clock latency.
REQ-014 c SHALL depend on no state, clock or reset, and SHALL be valid with clk idle.
REQ-015 At each rising clk edge with rst=0, c_q SHALL load the c sampled at that edge (1-cycle latency).
REQ-016 At each rising clk edge with rst=0, c_rise SHALL load c & ~c_q, using the pre-edge c_q, so each bit pulses for exactly one cycle per 0->1 transition of c_q.
REQ-017 A bit of c held at 1 SHALL yield exactly one c_rise pulse; c_rise SHALL NOT pulse again until c_q for that bit has returned to 0 for at least one cycle.
REQ-018 At each rising edge, hi_cnt SHALL increment by 1 when the sampled c is nonzero, and SHALL otherwise hold.
REQ-019 hi_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-020 Priority per edge SHALL be rst > clr_cnt > increment.
REQ-021 clr_cnt=1 with c nonzero SHALL leave hi_cnt at 0 for that edge, with no increment.
REQ-022 clr_cnt SHALL NOT affect c_q or c_rise.
REQ-023 X on a or b SHALL propagate to c per standard AND semantics; 0 & X SHALL equal 0.

Reset
REQ-024 With rst=1 at a rising edge: c_q, c_rise and hi_cnt SHALL all be 0 after that edge.
REQ-025 Reset SHALL NOT affect c.
REQ-026 On the first edge after rst deasserts, a nonzero c SHALL set c_q and c_rise for that bit, because pre-edge c_q=0.
REQ-027 Reset asserted mid-count SHALL discard the count; hi_cnt SHALL resume from 0.

Structure
REQ-028 Package and2_pkg SHALL hold the WIDTH and CNT_W default constants and the saturation-max helper constant.
REQ-029 The saturating counter SHALL be one sub-module, and2_sat_cnt, with inputs clk, rst, clr, inc and output cnt; all other logic SHALL be inline.

Verification
REQ-030 Scenario, no clock needed: a=0,b=0 -> c=0; a=1,b=0 -> c=0; a=1,b=1 -> c=1; a=0,b=1 -> c=0. Each value SHALL be checked 5 time units after the input change.
REQ-031 Scenario: rst=1 for 2 cycles with a=b=1 -> c=1, c_q=0, c_rise=0, hi_cnt=0. Release rst -> after the next edge c_q=1, c_rise=1, hi_cnt=1; after the following edge c_rise=0, hi_cnt=2.
REQ-032 Scenario: a=b=1 for 5 edges, then b=0 for 3 edges -> hi_cnt=5 and holds; exactly one c_rise pulse.
REQ-033 Scenario, CNT_W=4: c=1 for 20 edges -> hi_cnt=15 and stays at 15.
REQ-034 Scenario: hi_cnt=7, then clr_cnt=1 with c=1 for one edge -> hi_cnt=0; next edge with clr_cnt=0 -> hi_cnt=1.
REQ-035 Scenario, WIDTH=4: a=4'b1100, b=4'b1010 -> c=4'b1000. After one edge c_q=4'b1000, c_rise=4'b1000.
